// File: rtl/lockin_param_regbank.sv
// Multi-channel parameter bank for the lock-in processor.
// The CPU fills per-channel shadow registers over Avalon-MM; every channel is
// copied into the active registers (driven on out_port) in one atomic commit.
// A commit comes from a CTRL command, from sync_in while ARM is set (one-shot),
// or from sync_in while AUTO is set and shadow data is pending.
module lockin_param_regbank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic                     read_n,
  input  logic [DATA_W/8-1:0]      byteenable,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  input  logic                     sync_in,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     update_pulse
);

  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned ACT_BASE = NUM_CH + 2;
  localparam logic [ADDR_W-1:0] CTRL_A = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(NUM_CH + 1);

  logic [DATA_W-1:0] shadow_r [NUM_CH];
  logic [DATA_W-1:0] active_r [NUM_CH];
  logic              pending_r;
  logic              arm_r;
  logic              auto_r;
  logic [15:0]       cnt_r;

  logic              wr_s;
  logic              rd_s;
  logic              shadow_wr_s;
  logic              ctrl_wr_s;
  logic              cmd_commit_s;
  logic              commit_s;
  logic [DATA_W-1:0] rdata_s;

  // STATUS word: counter in the top half, flags in the low bits; narrow
  // buses simply keep the low DATA_W bits.
  function automatic logic [DATA_W-1:0] pack_status(input logic [15:0] cnt,
                                                    input logic auto_f,
                                                    input logic arm_f,
                                                    input logic pend_f);
    logic [31:0] word;
    word = {cnt, 13'd0, auto_f, arm_f, pend_f};
    return word[DATA_W-1:0];
  endfunction

  // CTRL readback: COMMIT is self-clearing so bit0 always reads back 0.
  function automatic logic [DATA_W-1:0] pack_ctrl(input logic auto_f,
                                                  input logic arm_f);
    logic [31:0] word;
    word = {29'd0, auto_f, arm_f, 1'b0};
    return word[DATA_W-1:0];
  endfunction

  assign wr_s         = chipselect & ~write_n;
  assign rd_s         = chipselect & ~read_n;
  assign shadow_wr_s  = wr_s & (address < CTRL_A);
  assign ctrl_wr_s    = wr_s & (address == CTRL_A);
  assign cmd_commit_s = ctrl_wr_s & writedata[0];
  // All sources merge into one commit, so coincident triggers count once.
  assign commit_s     = cmd_commit_s | (sync_in & arm_r) | (sync_in & auto_r & pending_r);

  // Read mux: address matches are mutually exclusive, so OR-ing the hits is safe; unmapped reads 0.
  always_comb begin
    rdata_s = {DATA_W{1'b0}};
    rdata_s = rdata_s | ((address == CTRL_A) ? pack_ctrl(auto_r, arm_r) : {DATA_W{1'b0}});
    rdata_s = rdata_s | ((address == STAT_A) ? pack_status(cnt_r, auto_r, arm_r, pending_r)
                                             : {DATA_W{1'b0}});
    for (int i = 0; i < NUM_CH; i++) begin
      rdata_s = rdata_s | ((address == ADDR_W'(i)) ? shadow_r[i] : {DATA_W{1'b0}});
      rdata_s = rdata_s | ((address == ADDR_W'(ACT_BASE + i)) ? active_r[i] : {DATA_W{1'b0}});
    end
  end

  // Drive out_port straight from the active registers, ch0 in the LSBs.
  always_comb begin
    out_port = {(NUM_CH*DATA_W){1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      out_port[i*DATA_W +: DATA_W] = active_r[i];
    end
  end

  // Shadow registers: byte-lane writes from the CPU.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_r[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        for (int b = 0; b < NB; b++) begin
          if (shadow_wr_s && (address == ADDR_W'(i)) && byteenable[b]) begin
            shadow_r[i][b*8 +: 8] <= writedata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Commit engine: copies shadows to active, tracks PENDING/ARM/AUTO and the commit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_r[i] <= RESET_VAL;
      end
      pending_r    <= 1'b0;
      arm_r        <= 1'b0;
      auto_r       <= 1'b0;
      cnt_r        <= 16'd0;
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= commit_s;
      if (commit_s) begin
        for (int i = 0; i < NUM_CH; i++) begin
          active_r[i] <= shadow_r[i];
        end
        cnt_r <= cnt_r + 16'd1;
      end
      // A shadow write racing a commit keeps PENDING: its data missed this commit.
      if (shadow_wr_s) begin
        pending_r <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end
      // A CTRL write defines ARM directly (a command commit in it disarms);
      // otherwise any commit consumes the one-shot.
      if (ctrl_wr_s) begin
        arm_r  <= writedata[1] & ~writedata[0];
        auto_r <= writedata[2];
      end else if (commit_s) begin
        arm_r <= 1'b0;
      end
    end
  end

  // Registered read data, updated only on a read strobe and held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= {DATA_W{1'b0}};
    end else if (rd_s) begin
      readdata <= rdata_s;
    end
  end

endmodule

// File: tb/tb_lockin_param_regbank.sv
// Scoreboard bench for lockin_param_regbank (NUM_CH=4, DATA_W=32, ADDR_W=4).
// Reads and commits push expectations into queues; a monitor on the falling
// edge pops them when readdata becomes valid or update_pulse is seen.
module tb_lockin_param_regbank;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   address = 4'd0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic         read_n = 1'b1;
  logic [3:0]   byteenable = 4'h0;
  logic [31:0]  writedata = 32'd0;
  logic [31:0]  readdata;
  logic         sync_in = 1'b0;
  logic [127:0] out_port;
  logic         update_pulse;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0]  rd_q[$];
  string        rd_name_q[$];
  logic [127:0] cm_q[$];
  logic         rd_seen = 1'b0;

  localparam logic [127:0] OUT_C1 = 128'h00000000_00000000_00AD00EF_00000000;
  localparam logic [127:0] OUT_C2 = 128'h00000000_00000000_00AD00EF_00000005;
  localparam logic [127:0] OUT_C3 = 128'h00000000_11111111_00AD00EF_00000005;
  localparam logic [127:0] OUT_C4 = 128'h00000000_22222222_00AD00EF_00000005;

  lockin_param_regbank #(.NUM_CH(4), .DATA_W(32), .ADDR_W(4), .RESET_VAL(32'd0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .sync_in(sync_in),
    .out_port(out_port), .update_pulse(update_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Track read strobes so the monitor knows when readdata is valid.
  always @(posedge clk) rd_seen <= chipselect & ~read_n;

  // Monitor: pop and compare on every valid read and every update pulse.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_read: got 0x%0h expected no read", readdata);
      end else begin
        check(rd_name_q.pop_front(), {96'd0, readdata}, {96'd0, rd_q.pop_front()});
      end
    end
    if (update_pulse === 1'b1) begin
      if (cm_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pulse: got pulse with out_port 0x%0h expected none", out_port);
      end else begin
        check("commit_out_port", out_port, cm_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                    input logic sync);
    address = a; writedata = d; byteenable = be; chipselect = 1'b1; write_n = 1'b0;
    sync_in = sync;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; sync_in = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    rd_q.push_back(exp); rd_name_q.push_back(name);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic pulse_sync();
    sync_in = 1'b1;
    @(posedge clk); #1;
    sync_in = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(2);
    reset = 1'b0;
    check("reset_out_port", out_port, 128'd0);
    check("reset_pulse", {127'd0, update_pulse}, 128'd0);
    rd(4'd6, 32'h0, "reset_active0");
    rd(4'd5, 32'h0, "reset_status");
    wr(4'd5, 32'hFFFFFFFF, 4'hF, 1'b0);
    rd(4'd5, 32'h0, "status_ro");
    rd(4'd10, 32'h0, "unmapped_read");

    // Byte-lane shadow write
    wr(4'd1, 32'hDEADBEEF, 4'b0101, 1'b0);
    rd(4'd1, 32'h00AD00EF, "shadow1_lanes");
    check("out_port_before_commit", out_port, 128'd0);
    rd(4'd5, 32'h00000001, "status_pending");

    // Command commit
    cm_q.push_back(OUT_C1);
    wr(4'd4, 32'h1, 4'hF, 1'b0);
    rd(4'd5, 32'h00010000, "status_after_cmd");
    rd(4'd7, 32'h00AD00EF, "active1");

    // Armed one-shot on sync_in
    wr(4'd4, 32'h2, 4'hF, 1'b0);
    rd(4'd5, 32'h00010002, "status_armed");
    wr(4'd0, 32'h5, 4'hF, 1'b0);
    check("ch0_waits_for_sync", out_port, OUT_C1);
    cm_q.push_back(OUT_C2);
    pulse_sync();
    rd(4'd5, 32'h00020000, "status_after_arm");
    rd(4'd4, 32'h0, "ctrl_arm_cleared");
    pulse_sync();
    idle(2);
    rd(4'd5, 32'h00020000, "status_second_sync");

    // AUTO with a shadow write racing sync_in
    wr(4'd4, 32'h4, 4'hF, 1'b0);
    wr(4'd2, 32'h11111111, 4'hF, 1'b0);
    cm_q.push_back(OUT_C3);
    wr(4'd2, 32'h22222222, 4'hF, 1'b1);
    rd(4'd5, 32'h00030005, "status_auto_race");
    cm_q.push_back(OUT_C4);
    pulse_sync();
    rd(4'd5, 32'h00040004, "status_auto_commit");
    pulse_sync();
    idle(1);
    rd(4'd5, 32'h00040004, "status_auto_nopend");

    // ARM and AUTO together: one-shot fires with nothing pending
    wr(4'd4, 32'h6, 4'hF, 1'b0);
    cm_q.push_back(OUT_C4);
    pulse_sync();
    rd(4'd5, 32'h00050004, "status_arm_auto");

    // Coincident CMD and armed sync_in: one commit
    wr(4'd4, 32'h2, 4'hF, 1'b0);
    cm_q.push_back(OUT_C4);
    wr(4'd4, 32'h5, 4'hF, 1'b1);
    idle(1);
    rd(4'd5, 32'h00060004, "status_single_commit");

    // Reset while armed with sync_in high
    wr(4'd3, 32'hCAFEF00D, 4'hF, 1'b0);
    wr(4'd4, 32'h2, 4'hF, 1'b0);
    reset = 1'b1; sync_in = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; sync_in = 1'b0;
    check("reset_mid_arm_pulse", {127'd0, update_pulse}, 128'd0);
    check("reset_mid_arm_out", out_port, 128'd0);
    rd(4'd5, 32'h0, "reset_mid_arm_status");
    rd(4'd3, 32'h0, "reset_mid_arm_shadow3");
    rd(4'd6, 32'h0, "reset_mid_arm_active0");

    // Counter wrap: 65535 back-to-back commands, then one more
    address = 4'd4; writedata = 32'h1; byteenable = 4'hF; chipselect = 1'b1; write_n = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      cm_q.push_back(128'd0);
      @(posedge clk); #1;
    end
    chipselect = 1'b0; write_n = 1'b1;
    rd(4'd5, 32'hFFFF0000, "counter_max");
    cm_q.push_back(128'd0);
    wr(4'd4, 32'h1, 4'hF, 1'b0);
    rd(4'd5, 32'h0, "counter_wrap");

    idle(3);
    check("read_queue_drained", 128'(rd_q.size()), 128'd0);
    check("commit_queue_drained", 128'(cm_q.size()), 128'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
